vc_port_control_logic: RTL and testbench

Virtual-channel input-port controller for the mesh NoC switch. It replaces the single-channel port control path with NUM_VC independent per-VC flit FIFOs, XY route computation on head flits, and a round-robin arbiter for route requests to the switch allocator. The same arbiter scheme selects the VC that drives the port's single output flit lane. It sits between the upstream link and the switch crossbar/allocator, one instance per switch input.

---
 rtl/vc_port_control_logic_if.sv | 35 +++
 rtl/vc_port_control_logic.sv | 254 +++++++++++++++++++++++++
 tb/tb_vc_port_control_logic.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vc_port_control_logic_if.sv
// Link, crossbar and switch-allocator signals of one VC input port.
interface vc_port_control_logic_if #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned VC_W          = 1,
  parameter int unsigned REQUEST_WIDTH = 3
);
  logic                     valid_in;
  logic                     ready_in;
  logic [DATA_WIDTH-1:0]    data_in;
  logic                     valid_out;
  logic                     ready_out;
  logic [DATA_WIDTH-1:0]    data_out;
  logic [VC_W-1:0]          vc_out;
  logic [REQUEST_WIDTH-1:0] dir_out;
  logic                     routeReserveRequestValid;
  logic [REQUEST_WIDTH-1:0] routeReserveRequest;
  logic                     routeReserveStatus;
  logic                     routeRelieve;
  logic [REQUEST_WIDTH-1:0] relieveDirection;
  logic                     protocol_error;

  modport slave (
    input  valid_in, data_in, ready_out, routeReserveStatus,
    output ready_in, valid_out, data_out, vc_out, dir_out,
           routeReserveRequestValid, routeReserveRequest,
           routeRelieve, relieveDirection, protocol_error
  );

  modport master (
    output valid_in, data_in, ready_out, routeReserveStatus,
    input  ready_in, valid_out, data_out, vc_out, dir_out,
           routeReserveRequestValid, routeReserveRequest,
           routeRelieve, relieveDirection, protocol_error
  );
endinterface

// File: rtl/vc_port_control_logic.sv
// VC input-port controller: per-VC FIFOs, XY routing on heads, round-robin
// route-request and output arbitration.
module vc_port_control_logic #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned TYPE_WIDTH    = 2,
  parameter int unsigned NUM_VC        = 2,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned COORD_W       = 2,
  parameter int unsigned X_POS         = 0,
  parameter int unsigned Y_POS         = 0,
  parameter int unsigned REQUEST_WIDTH = 3
) (
  input logic                    clk,
  input logic                    rst,
  vc_port_control_logic_if.slave bus
);
  localparam int unsigned VC_W  = $clog2(NUM_VC);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [TYPE_WIDTH-1:0] T_HEAD   = TYPE_WIDTH'(0);
  localparam logic [TYPE_WIDTH-1:0] T_TAIL   = TYPE_WIDTH'(2);
  localparam logic [TYPE_WIDTH-1:0] T_SINGLE = TYPE_WIDTH'(3);

  localparam logic [REQUEST_WIDTH-1:0] DIR_N = REQUEST_WIDTH'(0);
  localparam logic [REQUEST_WIDTH-1:0] DIR_S = REQUEST_WIDTH'(1);
  localparam logic [REQUEST_WIDTH-1:0] DIR_W = REQUEST_WIDTH'(2);
  localparam logic [REQUEST_WIDTH-1:0] DIR_E = REQUEST_WIDTH'(3);
  localparam logic [REQUEST_WIDTH-1:0] DIR_L = REQUEST_WIDTH'(4);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROUTE  = 2'd1,
    ST_ACTIVE = 2'd2
  } vc_state_e;

  function automatic logic is_head(input logic [TYPE_WIDTH-1:0] t);
    return (t == T_HEAD) || (t == T_SINGLE);
  endfunction

  function automatic logic is_last(input logic [TYPE_WIDTH-1:0] t);
    return (t == T_TAIL) || (t == T_SINGLE);
  endfunction

  function automatic logic [REQUEST_WIDTH-1:0] xy_route(input logic [COORD_W-1:0] dx,
                                                        input logic [COORD_W-1:0] dy);
    if (dx > COORD_W'(X_POS))      return DIR_E;
    else if (dx < COORD_W'(X_POS)) return DIR_W;
    else if (dy > COORD_W'(Y_POS)) return DIR_S;
    else if (dy < COORD_W'(Y_POS)) return DIR_N;
    else                           return DIR_L;
  endfunction

  vc_state_e                r_state     [NUM_VC];
  vc_state_e                w_state_nxt [NUM_VC];
  logic [REQUEST_WIDTH-1:0] r_dir       [NUM_VC];
  logic [REQUEST_WIDTH-1:0] w_dir_nxt   [NUM_VC];
  logic [DATA_WIDTH-1:0]    r_mem       [NUM_VC][FIFO_DEPTH];
  logic [PTR_W-1:0]         r_rd_ptr    [NUM_VC];
  logic [PTR_W-1:0]         r_wr_ptr    [NUM_VC];
  logic [CNT_W-1:0]         r_count     [NUM_VC];
  logic [CNT_W-1:0]         w_rcount    [NUM_VC];
  logic [DATA_WIDTH-1:0]    w_head      [NUM_VC];
  logic [DATA_WIDTH-1:0]    w_next      [NUM_VC];
  logic [NUM_VC-1:0]        r_fresh;
  logic [NUM_VC-1:0]        w_full;
  logic [NUM_VC-1:0]        w_avail;
  logic [NUM_VC-1:0]        w_avail2;
  logic [NUM_VC-1:0]        w_push_v;
  logic [NUM_VC-1:0]        w_pop;
  logic [VC_W-1:0]          w_vc_in;
  logic                     w_push;

  logic [VC_W-1:0]          r_out_ptr;
  logic [VC_W-1:0]          r_req_ptr;
  logic                     r_req_held;
  logic [VC_W-1:0]          r_req_vc;
  logic                     r_relieve;
  logic [REQUEST_WIDTH-1:0] r_relieve_dir;
  logic                     r_err;

  logic                     w_out_valid;
  logic [VC_W-1:0]          w_out_vc;
  logic                     w_req_valid;
  logic [VC_W-1:0]          w_req_vc;
  logic                     w_hs;
  logic                     w_grant;
  logic                     w_relieve;
  logic [REQUEST_WIDTH-1:0] w_relieve_dir;
  logic                     w_err_set;

  assign w_vc_in     = bus.data_in[DATA_WIDTH-TYPE_WIDTH-1 -: VC_W];
  assign bus.ready_in = !w_full[w_vc_in];
  assign w_push      = bus.valid_in && bus.ready_in;

  // A flit pushed last edge is counted for fullness but not yet readable.
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      w_rcount[v] = r_count[v] - CNT_W'(r_fresh[v]);
      w_full[v]   = (r_count[v] == CNT_W'(FIFO_DEPTH));
      w_avail[v]  = (w_rcount[v] != '0);
      w_avail2[v] = (w_rcount[v] > CNT_W'(1));
      w_head[v]   = r_mem[v][r_rd_ptr[v]];
      w_next[v]   = r_mem[v][r_rd_ptr[v] + PTR_W'(1)];
    end
  end

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      w_push_v[v] = w_push && (w_vc_in == VC_W'(v));
    end
  end

  // Arbitration and per-VC next state.
  always_comb begin
    w_state_nxt   = r_state;
    w_dir_nxt     = r_dir;
    w_pop         = '0;
    w_err_set     = 1'b0;
    w_relieve     = 1'b0;
    w_relieve_dir = '0;
    w_out_valid   = 1'b0;
    w_out_vc      = '0;
    w_req_valid   = 1'b0;
    w_req_vc      = '0;

    for (int i = 0; i < NUM_VC; i++) begin
      if (!w_out_valid && (r_state[VC_W'(r_out_ptr + VC_W'(i))] == ST_ACTIVE) &&
          w_avail[VC_W'(r_out_ptr + VC_W'(i))]) begin
        w_out_valid = 1'b1;
        w_out_vc    = VC_W'(r_out_ptr + VC_W'(i));
      end
    end

    if (r_req_held) begin
      w_req_valid = 1'b1;
      w_req_vc    = r_req_vc;
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        if (!w_req_valid && (r_state[VC_W'(r_req_ptr + VC_W'(i))] == ST_ROUTE)) begin
          w_req_valid = 1'b1;
          w_req_vc    = VC_W'(r_req_ptr + VC_W'(i));
        end
      end
    end

    w_hs    = w_out_valid && bus.ready_out;
    w_grant = w_req_valid && bus.routeReserveStatus;

    for (int v = 0; v < NUM_VC; v++) begin
      case (r_state[v])
        ST_IDLE: begin
          if (w_avail[v]) begin
            if (is_head(w_head[v][DATA_WIDTH-1 -: TYPE_WIDTH])) begin
              w_state_nxt[v] = ST_ROUTE;
              w_dir_nxt[v]   = xy_route(w_head[v][COORD_W-1:0], w_head[v][2*COORD_W-1:COORD_W]);
            end else begin
              w_pop[v]  = 1'b1;
              w_err_set = 1'b1;
            end
          end
        end
        ST_ROUTE: begin
          if (w_grant && (w_req_vc == VC_W'(v))) w_state_nxt[v] = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (w_hs && (w_out_vc == VC_W'(v))) begin
            w_pop[v] = 1'b1;
            if (is_last(w_head[v][DATA_WIDTH-1 -: TYPE_WIDTH])) begin
              w_relieve     = 1'b1;
              w_relieve_dir = r_dir[v];
              // A queued head behind the tail is routed on the same edge.
              if (w_avail2[v] && is_head(w_next[v][DATA_WIDTH-1 -: TYPE_WIDTH])) begin
                w_state_nxt[v] = ST_ROUTE;
                w_dir_nxt[v]   = xy_route(w_next[v][COORD_W-1:0],
                                          w_next[v][2*COORD_W-1:COORD_W]);
              end else begin
                w_state_nxt[v] = ST_IDLE;
              end
            end
          end
        end
        default: w_state_nxt[v] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        r_state[v] <= ST_IDLE;
        r_dir[v]   <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        r_state[v] <= w_state_nxt[v];
        r_dir[v]   <= w_dir_nxt[v];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fresh <= '0;
      for (int v = 0; v < NUM_VC; v++) begin
        r_rd_ptr[v] <= '0;
        r_wr_ptr[v] <= '0;
        r_count[v]  <= '0;
      end
    end else begin
      r_fresh <= w_push_v;
      for (int v = 0; v < NUM_VC; v++) begin
        if (w_push_v[v]) r_wr_ptr[v] <= r_wr_ptr[v] + PTR_W'(1);
        if (w_pop[v])    r_rd_ptr[v] <= r_rd_ptr[v] + PTR_W'(1);
        if (w_push_v[v] && !w_pop[v])      r_count[v] <= r_count[v] + CNT_W'(1);
        else if (!w_push_v[v] && w_pop[v]) r_count[v] <= r_count[v] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[w_vc_in][r_wr_ptr[w_vc_in]] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_ptr     <= '0;
      r_req_ptr     <= '0;
      r_req_held    <= 1'b0;
      r_req_vc      <= '0;
      r_relieve     <= 1'b0;
      r_relieve_dir <= '0;
      r_err         <= 1'b0;
    end else begin
      if (w_hs)    r_out_ptr <= w_out_vc + VC_W'(1);
      if (w_grant) r_req_ptr <= w_req_vc + VC_W'(1);
      r_req_held    <= w_req_valid && !bus.routeReserveStatus;
      r_req_vc      <= w_req_vc;
      r_relieve     <= w_relieve;
      r_relieve_dir <= w_relieve_dir;
      r_err         <= r_err || w_err_set;
    end
  end

  assign bus.valid_out                = w_out_valid;
  assign bus.vc_out                   = w_out_vc;
  assign bus.data_out                 = w_out_valid ? w_head[w_out_vc] : '0;
  assign bus.dir_out                  = w_out_valid ? r_dir[w_out_vc] : '0;
  assign bus.routeReserveRequestValid = w_req_valid;
  assign bus.routeReserveRequest      = w_req_valid ? r_dir[w_req_vc] : '0;
  assign bus.routeRelieve             = r_relieve;
  assign bus.relieveDirection         = r_relieve_dir;
  assign bus.protocol_error           = r_err;
endmodule

// File: tb/tb_vc_port_control_logic.sv
// Directed bench for vc_port_control_logic, switch at (1,1).
module tb_vc_port_control_logic;
  localparam logic [1:0] HD = 2'd0;
  localparam logic [1:0] BD = 2'd1;
  localparam logic [1:0] TL = 2'd2;
  localparam logic [1:0] SG = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  vc_port_control_logic_if #(.DATA_WIDTH(16), .VC_W(1), .REQUEST_WIDTH(3)) bus();

  vc_port_control_logic #(
    .DATA_WIDTH(16), .TYPE_WIDTH(2), .NUM_VC(2), .FIFO_DEPTH(4), .COORD_W(2),
    .X_POS(1), .Y_POS(1), .REQUEST_WIDTH(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic [1:0] t, input logic v, input logic [8:0] pl,
                                     input logic [1:0] dy, input logic [1:0] dx);
    return {t, v, pl, dy, dx};
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_single(input logic vcb, input logic [1:0] dy, input logic [1:0] dx,
                             input logic [2:0] exp_dir, input string tag);
    logic [15:0] f;
    f = mk(SG, vcb, 9'h15A, dy, dx);
    bus.valid_in = 1'b1;
    bus.data_in  = f;
    #1;
    check_eq({tag, "_rdy"}, 16'(bus.ready_in), 16'd1);
    tick();
    bus.valid_in = 1'b0;
    #1;
    check_eq({tag, "_noreq0"}, 16'(bus.routeReserveRequestValid), 16'd0);
    tick(); #1;
    check_eq({tag, "_noreq1"}, 16'(bus.routeReserveRequestValid), 16'd0);
    tick(); #1;
    check_eq({tag, "_reqv"}, 16'(bus.routeReserveRequestValid), 16'd1);
    check_eq({tag, "_reqdir"}, 16'(bus.routeReserveRequest), 16'(exp_dir));
    bus.routeReserveStatus = 1'b1;
    tick();
    bus.routeReserveStatus = 1'b0;
    #1;
    check_eq({tag, "_vout"}, 16'(bus.valid_out), 16'd1);
    check_eq({tag, "_vc"}, 16'(bus.vc_out), 16'(vcb));
    check_eq({tag, "_dir"}, 16'(bus.dir_out), 16'(exp_dir));
    check_eq({tag, "_data"}, bus.data_out, f);
    check_eq({tag, "_reqoff"}, 16'(bus.routeReserveRequestValid), 16'd0);
    bus.ready_out = 1'b1;
    tick();
    bus.ready_out = 1'b0;
    #1;
    check_eq({tag, "_rel"}, 16'(bus.routeRelieve), 16'd1);
    check_eq({tag, "_reldir"}, 16'(bus.relieveDirection), 16'(exp_dir));
    check_eq({tag, "_drained"}, 16'(bus.valid_out), 16'd0);
    tick(); #1;
    check_eq({tag, "_relend"}, 16'(bus.routeRelieve), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] pseq [8];
    logic [15:0] oseq [8];
    logic [15:0] h2, b2a, b2b, b2c, bx, t2, h3;

    bus.valid_in           = 1'b0;
    bus.data_in            = '0;
    bus.ready_out          = 1'b0;
    bus.routeReserveStatus = 1'b0;

    // Reset state while rst is held low
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_valid_out", 16'(bus.valid_out), 16'd0);
    check_eq("rst_req_valid", 16'(bus.routeReserveRequestValid), 16'd0);
    check_eq("rst_relieve", 16'(bus.routeRelieve), 16'd0);
    check_eq("rst_perr", 16'(bus.protocol_error), 16'd0);
    check_eq("rst_data_out", bus.data_out, 16'd0);
    check_eq("rst_vc_out", 16'(bus.vc_out), 16'd0);
    check_eq("rst_dir_out", 16'(bus.dir_out), 16'd0);
    check_eq("rst_req", 16'(bus.routeReserveRequest), 16'd0);
    check_eq("rst_reldir", 16'(bus.relieveDirection), 16'd0);
    check_eq("rst_ready_in", 16'(bus.ready_in), 16'd1);
    tick();
    rst = 1'b1;
    #1;
    check_eq("post_rst_ready_in", 16'(bus.ready_in), 16'd1);

    // XY routing with the switch at (1,1)
    send_single(1'b0, 2'd1, 2'd2, 3'd3, "east");
    send_single(1'b0, 2'd1, 2'd1, 3'd4, "local");
    send_single(1'b0, 2'd0, 2'd1, 3'd0, "north");
    send_single(1'b0, 2'd2, 2'd1, 3'd1, "south");
    send_single(1'b1, 2'd3, 2'd0, 3'd2, "west");

    // Two 4-flit packets, VC0 East and VC1 Local, both FIFOs full
    pseq[0] = mk(HD, 1'b0, 9'h010, 2'd1, 2'd2);
    pseq[1] = mk(HD, 1'b1, 9'h020, 2'd1, 2'd1);
    pseq[2] = mk(BD, 1'b0, 9'h011, 2'd0, 2'd0);
    pseq[3] = mk(BD, 1'b0, 9'h012, 2'd0, 2'd0);
    pseq[4] = mk(TL, 1'b0, 9'h013, 2'd0, 2'd0);
    pseq[5] = mk(BD, 1'b1, 9'h021, 2'd0, 2'd0);
    pseq[6] = mk(BD, 1'b1, 9'h022, 2'd0, 2'd0);
    pseq[7] = mk(TL, 1'b1, 9'h023, 2'd0, 2'd0);
    oseq[0] = pseq[0]; oseq[1] = pseq[1]; oseq[2] = pseq[2]; oseq[3] = pseq[5];
    oseq[4] = pseq[3]; oseq[5] = pseq[6]; oseq[6] = pseq[4]; oseq[7] = pseq[7];
    for (int k = 0; k < 8; k++) begin
      bus.valid_in = 1'b1;
      bus.data_in  = pseq[k];
      tick();
    end
    bus.valid_in = 1'b0;
    #1;
    check_eq("alt_req0_v", 16'(bus.routeReserveRequestValid), 16'd1);
    check_eq("alt_req0_dir", 16'(bus.routeReserveRequest), 16'd3);
    bus.routeReserveStatus = 1'b1;
    tick(); #1;
    check_eq("alt_req1_v", 16'(bus.routeReserveRequestValid), 16'd1);
    check_eq("alt_req1_dir", 16'(bus.routeReserveRequest), 16'd4);
    check_eq("alt_first_vout", 16'(bus.valid_out), 16'd1);
    check_eq("alt_first_vc", 16'(bus.vc_out), 16'd0);
    tick();
    bus.routeReserveStatus = 1'b0;
    #1;
    check_eq("alt_req_done", 16'(bus.routeReserveRequestValid), 16'd0);
    bus.ready_out = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("alt_vc_%0d", k), 16'(bus.vc_out), 16'(k % 2));
      check_eq($sformatf("alt_data_%0d", k), bus.data_out, oseq[k]);
      if (k == 7) begin
        check_eq("alt_rel_vc0", 16'(bus.routeRelieve), 16'd1);
        check_eq("alt_reldir_vc0", 16'(bus.relieveDirection), 16'd3);
      end
      tick(); #1;
    end
    bus.ready_out = 1'b0;
    check_eq("alt_rel_vc1", 16'(bus.routeRelieve), 16'd1);
    check_eq("alt_reldir_vc1", 16'(bus.relieveDirection), 16'd4);
    check_eq("alt_empty", 16'(bus.valid_out), 16'd0);

    // Fill VC1, then push and pop around the full boundary
    h2  = mk(HD, 1'b1, 9'h030, 2'd1, 2'd1);
    b2a = mk(BD, 1'b1, 9'h031, 2'd0, 2'd0);
    b2b = mk(BD, 1'b1, 9'h032, 2'd0, 2'd0);
    b2c = mk(BD, 1'b1, 9'h033, 2'd0, 2'd0);
    bx  = mk(BD, 1'b1, 9'h034, 2'd0, 2'd0);
    t2  = mk(TL, 1'b1, 9'h035, 2'd0, 2'd0);
    bus.valid_in = 1'b1;
    bus.data_in = h2;  tick();
    bus.data_in = b2a; tick();
    bus.data_in = b2b; tick();
    bus.data_in = b2c; tick();
    bus.valid_in = 1'b0;
    bus.data_in  = mk(BD, 1'b1, 9'h1FF, 2'd0, 2'd0);
    #1;
    check_eq("full_vc1_rdy", 16'(bus.ready_in), 16'd0);
    bus.data_in = mk(BD, 1'b0, 9'h1FF, 2'd0, 2'd0);
    #1;
    check_eq("full_vc0_rdy", 16'(bus.ready_in), 16'd1);
    check_eq("full_req_v", 16'(bus.routeReserveRequestValid), 16'd1);
    check_eq("full_req_dir", 16'(bus.routeReserveRequest), 16'd4);
    bus.routeReserveStatus = 1'b1;
    tick();
    bus.routeReserveStatus = 1'b0;
    #1;
    check_eq("full_vout", 16'(bus.valid_out), 16'd1);
    check_eq("full_vc", 16'(bus.vc_out), 16'd1);
    check_eq("full_data_h", bus.data_out, h2);
    bus.valid_in  = 1'b1;
    bus.data_in   = bx;
    bus.ready_out = 1'b1;
    #1;
    check_eq("full_pop_rdy", 16'(bus.ready_in), 16'd0);
    tick(); #1;
    check_eq("after_pop_rdy", 16'(bus.ready_in), 16'd1);
    check_eq("after_pop_data", bus.data_out, b2a);
    tick(); #1;
    check_eq("push_pop_rdy", 16'(bus.ready_in), 16'd1);
    check_eq("push_pop_data", bus.data_out, b2b);
    bus.ready_out = 1'b0;
    bus.data_in   = t2;
    tick();
    bus.valid_in = 1'b0;
    #1;
    check_eq("refull_rdy", 16'(bus.ready_in), 16'd0);
    oseq[0] = b2b; oseq[1] = b2c; oseq[2] = bx; oseq[3] = t2;
    bus.ready_out = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("drain_data_%0d", k), bus.data_out, oseq[k]);
      tick(); #1;
    end
    bus.ready_out = 1'b0;
    check_eq("drain_rel", 16'(bus.routeRelieve), 16'd1);
    check_eq("drain_reldir", 16'(bus.relieveDirection), 16'd4);

    // Body flit into an IDLE VC
    bus.valid_in = 1'b1;
    bus.data_in  = mk(BD, 1'b0, 9'h040, 2'd0, 2'd0);
    tick();
    bus.valid_in = 1'b0;
    #1;
    check_eq("perr_pre", 16'(bus.protocol_error), 16'd0);
    tick(); #1;
    tick(); #1;
    check_eq("perr_set", 16'(bus.protocol_error), 16'd1);
    check_eq("perr_noreq", 16'(bus.routeReserveRequestValid), 16'd0);
    repeat (3) tick();
    #1;
    check_eq("perr_sticky", 16'(bus.protocol_error), 16'd1);
    check_eq("perr_noreq2", 16'(bus.routeReserveRequestValid), 16'd0);
    check_eq("perr_novout", 16'(bus.valid_out), 16'd0);

    // Asynchronous reset in the middle of an active packet
    h3 = mk(HD, 1'b0, 9'h050, 2'd1, 2'd2);
    bus.valid_in = 1'b1;
    bus.data_in  = h3;
    tick();
    bus.valid_in = 1'b0;
    tick();
    tick(); #1;
    check_eq("mid_req_v", 16'(bus.routeReserveRequestValid), 16'd1);
    check_eq("mid_req_dir", 16'(bus.routeReserveRequest), 16'd3);
    bus.routeReserveStatus = 1'b1;
    tick();
    bus.routeReserveStatus = 1'b0;
    #1;
    check_eq("mid_vout", 16'(bus.valid_out), 16'd1);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_vout", 16'(bus.valid_out), 16'd0);
    check_eq("mid_rst_data", bus.data_out, 16'd0);
    check_eq("mid_rst_dir", 16'(bus.dir_out), 16'd0);
    check_eq("mid_rst_perr", 16'(bus.protocol_error), 16'd0);
    check_eq("mid_rst_req", 16'(bus.routeReserveRequestValid), 16'd0);
    check_eq("mid_rst_rel", 16'(bus.routeRelieve), 16'd0);
    tick();
    rst = 1'b1;
    tick(); #1;
    check_eq("post_mid_rdy", 16'(bus.ready_in), 16'd1);
    check_eq("post_mid_vout", 16'(bus.valid_out), 16'd0);
    check_eq("post_mid_req", 16'(bus.routeReserveRequestValid), 16'd0);
    check_eq("post_mid_rel", 16'(bus.routeRelieve), 16'd0);
    tick(); #1;
    check_eq("post_mid_rel2", 16'(bus.routeRelieve), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
